// File: rtl/door_motor_ctrl.sv
// rtl/door_motor_ctrl.sv - limit-switched up/down door motor controller
// Synchronised, debounced inputs drive a registered FSM with dead-time reversal, watchdog and fault latch.
module door_motor_ctrl #(
  parameter int DEB_CYCLES      = 4,
  parameter int DEADTIME_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       Up_Max,
  input  logic       Down_Max,
  input  logic       Obstruct,
  output logic       Up_Motor,
  output logic       Down_Motor,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MV_UP   = 3'd1,
    MV_DOWN = 3'd2,
    DEAD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  // Bit order of the input vectors: {obstruct, down limit, up limit, activate}
  logic [3:0]       raw_in;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       filt;
  logic [DEB_W-1:0] deb_cnt [4];
  logic             act_q;

  logic act_f;
  logic up_f;
  logic dn_f;
  logic obs_f;
  logic act_p;

  assign raw_in = {Obstruct, Down_Max, Up_Max, Activate};
  assign act_f  = filt[0];
  assign up_f   = filt[1];
  assign dn_f   = filt[2];
  assign obs_f  = filt[3];
  assign act_p  = act_f & ~act_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // A filtered bit flips only after DEB_CYCLES consecutive synced samples disagree with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      filt  <= '0;
      act_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      act_q <= act_f;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  state_t           state;
  state_t           state_n;
  logic             pend_up;
  logic             pend_up_n;
  logic             last_up;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    state_n   = state;
    pend_up_n = pend_up;
    case (state)
      IDLE: begin
        if (up_f && dn_f) begin
          state_n = FAULT;
        end else if (act_p && dn_f) begin
          state_n = MV_UP;
        end else if (act_p && up_f) begin
          state_n = MV_DOWN;
        end else if (act_p) begin
          // Stopped mid-travel: restart in the opposite direction after the dead time.
          state_n   = DEAD;
          pend_up_n = ~last_up;
        end
      end
      MV_UP: begin
        if (up_f && dn_f) begin
          state_n = FAULT;
        end else if (up_f || act_p) begin
          state_n = IDLE;
        end else if (cnt == TMO_LAST) begin
          state_n = FAULT;
        end
      end
      MV_DOWN: begin
        if (up_f && dn_f) begin
          state_n = FAULT;
        end else if (dn_f) begin
          state_n = IDLE;
        end else if (obs_f) begin
          state_n   = DEAD;
          pend_up_n = 1'b1;
        end else if (act_p) begin
          state_n = IDLE;
        end else if (cnt == TMO_LAST) begin
          state_n = FAULT;
        end
      end
      DEAD: begin
        if (up_f && dn_f) begin
          state_n = FAULT;
        end else if (cnt >= DEAD_LAST) begin
          if (pend_up) begin
            state_n = up_f ? IDLE : MV_UP;
          end else begin
            state_n = dn_f ? IDLE : MV_DOWN;
          end
        end
      end
      FAULT: begin
        if (act_p && (up_f ^ dn_f)) begin
          state_n = IDLE;
        end
      end
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pend_up    <= 1'b0;
      last_up    <= 1'b0;
      cnt        <= '0;
      Up_Motor   <= 1'b0;
      Down_Motor <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      state   <= state_n;
      pend_up <= pend_up_n;
      if (state_n == MV_UP) begin
        last_up <= 1'b1;
      end else if (state_n == MV_DOWN) begin
        last_up <= 1'b0;
      end
      if (state_n != state) begin
        cnt <= '0;
      end else if ((state == MV_UP || state == MV_DOWN || state == DEAD) && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      Up_Motor   <= (state_n == MV_UP);
      Down_Motor <= (state_n == MV_DOWN);
      Fault      <= (state_n == FAULT);
    end
  end

  assign State = state;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// tb/tb_door_motor_ctrl.sv - scoreboard bench for door_motor_ctrl against a window-based reference model
module tb_door_motor_ctrl;

  localparam int DEB = 4;
  localparam int DT  = 8;
  localparam int TMO = 50;

  localparam int S_IDLE  = 0;
  localparam int S_UP    = 1;
  localparam int S_DOWN  = 2;
  localparam int S_DEAD  = 3;
  localparam int S_FAULT = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Activate = 1'b0;
  logic       Up_Max = 1'b0;
  logic       Down_Max = 1'b0;
  logic       Obstruct = 1'b0;
  logic       Up_Motor;
  logic       Down_Motor;
  logic       Fault;
  logic [2:0] State;

  door_motor_ctrl #(
    .DEB_CYCLES(DEB),
    .DEADTIME_CYCLES(DT),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Activate(Activate),
    .Up_Max(Up_Max),
    .Down_Max(Down_Max),
    .Obstruct(Obstruct),
    .Up_Motor(Up_Motor),
    .Down_Motor(Down_Motor),
    .Fault(Fault),
    .State(State)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Expected {state, up_motor, down_motor, fault} after each rising edge
  logic [5:0] exp_q[$];
  logic [3:0] cur_raw = 4'h0;
  logic       cur_rn  = 1'b0;

  // Reference model: raw inputs reach the filter two edges late; a filtered bit
  // flips when the last DEB delayed samples all disagree with it.
  logic [3:0] raw_q[$];
  logic [3:0] win[$];
  logic [3:0] m_filt;
  logic       m_prev_act;
  int         m_mode;
  int         m_age;
  bit         m_last_up;
  bit         m_pend_up;

  function automatic logic [5:0] pack_exp(input int mode);
    return {3'(mode), logic'(mode == S_UP), logic'(mode == S_DOWN), logic'(mode == S_FAULT)};
  endfunction

  function automatic void m_reset();
    raw_q.delete();
    raw_q.push_back(4'h0);
    raw_q.push_back(4'h0);
    win.delete();
    m_filt     = 4'h0;
    m_prev_act = 1'b0;
    m_mode     = S_IDLE;
    m_age      = 0;
    m_last_up  = 1'b0;
    m_pend_up  = 1'b0;
  endfunction

  function automatic logic [5:0] model_edge(input logic [3:0] raw, input logic rn);
    bit         ap;
    bit         uf;
    bit         df;
    bit         of;
    bit         all_diff;
    int         nxt;
    logic [3:0] smp;
    if (!rn) begin
      m_reset();
      return pack_exp(S_IDLE);
    end
    ap  = m_filt[0] && !m_prev_act;
    uf  = m_filt[1];
    df  = m_filt[2];
    of  = m_filt[3];
    nxt = m_mode;
    m_age++;
    case (m_mode)
      S_IDLE: begin
        if (uf && df) nxt = S_FAULT;
        else if (ap && df) nxt = S_UP;
        else if (ap && uf) nxt = S_DOWN;
        else if (ap) begin
          nxt       = S_DEAD;
          m_pend_up = !m_last_up;
        end
      end
      S_UP: begin
        m_last_up = 1'b1;
        if (uf && df) nxt = S_FAULT;
        else if (uf) nxt = S_IDLE;
        else if (ap) nxt = S_IDLE;
        else if (m_age >= TMO) nxt = S_FAULT;
      end
      S_DOWN: begin
        m_last_up = 1'b0;
        if (uf && df) nxt = S_FAULT;
        else if (df) nxt = S_IDLE;
        else if (of) begin
          nxt       = S_DEAD;
          m_pend_up = 1'b1;
        end
        else if (ap) nxt = S_IDLE;
        else if (m_age >= TMO) nxt = S_FAULT;
      end
      S_DEAD: begin
        if (uf && df) nxt = S_FAULT;
        else if (m_age >= DT) begin
          if (m_pend_up) nxt = uf ? S_IDLE : S_UP;
          else nxt = df ? S_IDLE : S_DOWN;
        end
      end
      default: begin
        if (ap && (uf != df)) nxt = S_IDLE;
      end
    endcase
    if (nxt != m_mode) begin
      m_mode = nxt;
      m_age  = 0;
    end
    m_prev_act = m_filt[0];
    smp = raw_q.pop_front();
    raw_q.push_back(raw);
    win.push_back(smp);
    if (win.size() > DEB) void'(win.pop_front());
    if (win.size() == DEB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (win[j]) if (win[j][i] == m_filt[i]) all_diff = 1'b0;
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
    end
    return pack_exp(m_mode);
  endfunction

  task automatic cmp(input string nm, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got state=%0d up=%0b down=%0b fault=%0b, want state=%0d up=%0b down=%0b fault=%0b",
               nm, $time, got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  // Drives one clock: the model consumes the edge, then the next inputs are applied.
  task automatic step(input logic [3:0] nraw, input logic nrn);
    @(posedge CLK);
    exp_q.push_back(model_edge(cur_raw, cur_rn));
    #1;
    {Obstruct, Down_Max, Up_Max, Activate} = nraw;
    cur_raw = nraw;
    RST     = nrn;
    if (!nrn) begin
      #1;
      cmp("async_reset", {State, Up_Motor, Down_Motor, Fault}, 6'h0);
      exp_q[exp_q.size() - 1] = 6'h0;
    end
    cur_rn = nrn;
  endtask

  task automatic hold(input int n, input logic [3:0] r);
    repeat (n) step(r, 1'b1);
  endtask

  function automatic logic [3:0] pk(input logic a, input logic u, input logic d, input logic o);
    return {o, d, u, a};
  endfunction

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("scoreboard", {State, Up_Motor, Down_Motor, Fault}, e);
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    int         dur;
    int         lim;
    m_reset();
    repeat (3) step(4'h0, 1'b0);
    hold(4, 4'h0);
    hold(10, pk(1, 0, 1, 0));
    hold(10, pk(0, 0, 0, 0));
    hold(10, pk(0, 1, 0, 0));
    hold(3, pk(1, 1, 0, 0));
    hold(10, pk(0, 1, 0, 0));
    for (int k = 0; k < 5; k++) begin
      hold(2, pk(0, 0, 0, 0));
      hold(2, pk(0, 1, 0, 0));
    end
    hold(6, pk(0, 1, 0, 0));
    hold(8, pk(1, 1, 0, 0));
    hold(10, pk(0, 0, 0, 0));
    hold(20, pk(0, 0, 0, 1));
    hold(60, pk(0, 0, 0, 0));
    hold(10, pk(1, 0, 1, 0));
    hold(10, pk(0, 0, 1, 0));
    hold(8, pk(1, 0, 1, 0));
    hold(10, pk(0, 0, 0, 0));
    hold(8, pk(1, 0, 0, 0));
    hold(8, pk(0, 0, 0, 0));
    hold(8, pk(1, 0, 0, 0));
    hold(20, pk(0, 0, 0, 0));
    hold(10, pk(0, 1, 1, 0));
    hold(8, pk(0, 0, 1, 0));
    hold(8, pk(1, 0, 1, 0));
    hold(8, pk(0, 1, 0, 0));
    hold(8, pk(1, 1, 0, 0));
    hold(6, pk(0, 0, 0, 0));
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    hold(12, pk(0, 0, 0, 0));
    for (int s = 0; s < 300; s++) begin
      r[0] = ($urandom_range(0, 9) < 3);
      lim  = $urandom_range(0, 19);
      r[1] = (lim == 0) || (lim >= 1 && lim <= 6);
      r[2] = (lim == 0) || (lim >= 7 && lim <= 12);
      r[3] = ($urandom_range(0, 4) == 0);
      dur  = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 90) : $urandom_range(1, 20);
      if ($urandom_range(0, 79) == 0) begin
        step(r, 1'b0);
        step(r, 1'b0);
      end
      hold(dur, r);
    end
    @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
